// File: rtl/ps2_color_sel.sv
// PS/2 keyboard receiver and digit-key colour selector for the VGA path.
// Receives 11-bit PS/2 frames and checks parity, stop bit and inter-edge
// timeout. Set-2 make codes for digits 0-7 select a 3-bit colour. Break
// (F0) and extended (E0) prefixes suppress the byte that follows them.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | waiting for a start bit (falling edge, data 0)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking stop bit and parity, then publishing
module ps2_color_sel #(
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       pxlClk25Mhz,
    input  logic       rstN,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [2:0] pxl_color,
    output logic [7:0] scanCode,
    output logic       codeValid,
    output logic       frameErr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Down-counter reload: the terminal count of zero is reached after
    // TIMEOUT_CYCLES-1 cycles without a PS/2 falling edge.
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fall;
    logic          bit_in;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    color_q, color_d;
    logic [7:0]    scan_q, scan_d;
    logic          cv_q, cv_d;
    logic          fe_q, fe_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic          tmo_hit;
    logic          good;

    // Two-stage synchronisers for both PS/2 lines plus the clock edge register.
    always_ff @(posedge pxlClk25Mhz or negedge rstN) begin
        if (!rstN) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2Clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2Data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall   = clk_prev_q & ~clk_s2_q;
    assign bit_in = dat_s2_q;

    // A falling edge in the terminal-count cycle wins and keeps the frame alive.
    assign tmo_hit = (state_q != S_IDLE) && !fall && (tmo_q == '0);

    // Frame FSM, timeout timer and scan-code decoder next-state logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        color_d   = color_q;
        scan_d    = scan_q;
        cv_d      = 1'b0;
        fe_d      = 1'b0;
        brk_d     = brk_q;
        ext_d     = ext_q;
        good      = 1'b0;

        if ((state_q == S_IDLE) || fall) begin
            tmo_d = TMO_LOAD;
        end else if (tmo_q != '0) begin
            tmo_d = tmo_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // A falling edge with data high is a glitch, not a start bit.
                if (fall && !bit_in) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = bit_in;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (bit_in && (^{shift_q, par_q})) begin
                        good = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_hit) begin
            state_d = S_IDLE;
            fe_d    = 1'b1;
        end

        if (good) begin
            scan_d = shift_q;
            cv_d   = 1'b1;
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (brk_q || ext_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                case (shift_q)
                    8'h45:   color_d = 3'd0;
                    8'h16:   color_d = 3'd1;
                    8'h1E:   color_d = 3'd2;
                    8'h26:   color_d = 3'd3;
                    8'h25:   color_d = 3'd4;
                    8'h2E:   color_d = 3'd5;
                    8'h36:   color_d = 3'd6;
                    8'h3D:   color_d = 3'd7;
                    default: color_d = color_q;
                endcase
            end
        end
    end

    // State, timer, decoder flags and registered outputs.
    always_ff @(posedge pxlClk25Mhz or negedge rstN) begin
        if (!rstN) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            tmo_q     <= TMO_LOAD;
            color_q   <= 3'd0;
            scan_q    <= 8'h00;
            cv_q      <= 1'b0;
            fe_q      <= 1'b0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            color_q   <= color_d;
            scan_q    <= scan_d;
            cv_q      <= cv_d;
            fe_q      <= fe_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
        end
    end

    assign pxl_color = color_q;
    assign scanCode  = scan_q;
    assign codeValid = cv_q;
    assign frameErr  = fe_q;

endmodule

// File: tb/tb_ps2_color_sel.sv
// Directed and randomised frames against a behavioural key/colour model.
module tb_ps2_color_sel;

    localparam int TMO  = 200;
    localparam int HALF = 10;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [2:0] pxl_color;
    logic [7:0] scanCode;
    logic       codeValid;
    logic       frameErr;

    int total = 0;
    int bad   = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;

    logic [2:0] m_color;
    logic [7:0] m_scan;
    bit         m_brk;
    bit         m_ext;
    logic [7:0] digits [8];

    ps2_color_sel #(.TIMEOUT_CYCLES(TMO)) dut (
        .pxlClk25Mhz(clk),
        .rstN       (rst_n),
        .ps2Clk     (ps2_clk),
        .ps2Data    (ps2_dat),
        .pxl_color  (pxl_color),
        .scanCode   (scanCode),
        .codeValid  (codeValid),
        .frameErr   (frameErr)
    );

    always #20 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (codeValid) cv_cnt <= cv_cnt + 1;
        if (frameErr) fe_cnt <= fe_cnt + 1;
        if (codeValid && frameErr) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_color = 3'd0;
        m_scan  = 8'h00;
        m_brk   = 1'b0;
        m_ext   = 1'b0;
    endtask

    task automatic model_apply(input logic [7:0] b);
        m_scan = b;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (m_brk || m_ext) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (digits[i] == b) m_color = 3'(i);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = bad_par ? (^b) : ~(^b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(bad_stop ? 1'b0 : 1'b1);
        ps2_dat = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] b,
                               input bit bad_par, input bit bad_stop);
        int cv0, fe0;
        bit good;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        good = !bad_par && !bad_stop;
        send_frame(b, bad_par, bad_stop);
        if (good) model_apply(b);
        check($sformatf("%s/codeValid", tag), 32'(cv_cnt - cv0), good ? 32'd1 : 32'd0);
        check($sformatf("%s/frameErr", tag), 32'(fe_cnt - fe0), good ? 32'd0 : 32'd1);
        check($sformatf("%s/scanCode", tag), 32'(scanCode), 32'(m_scan));
        check($sformatf("%s/pxl_color", tag), 32'(pxl_color), 32'(m_color));
    endtask

    initial begin
        int cv0, fe0, r, e;
        logic [7:0] b;
        digits = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};
        model_reset();

        // Power-on reset values.
        wait_clk(5);
        check("rst/pxl_color", 32'(pxl_color), 32'd0);
        check("rst/scanCode", 32'(scanCode), 32'd0);
        check("rst/codeValid", 32'(codeValid), 32'd0);
        check("rst/frameErr", 32'(frameErr), 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        frame_check("first_1E", 8'h1E, 0, 0);

        // Make / break / make.
        frame_check("mk_25", 8'h25, 0, 0);
        frame_check("brk_F0", 8'hF0, 0, 0);
        frame_check("brk_25", 8'h25, 0, 0);
        check("brk/color_held", 32'(pxl_color), 32'd4);

        // Extended prefix suppresses the next digit.
        frame_check("ext_E0", 8'hE0, 0, 0);
        frame_check("ext_16", 8'h16, 0, 0);
        check("ext/color_held", 32'(pxl_color), 32'd4);
        frame_check("plain_16", 8'h16, 0, 0);
        check("plain_16/color", 32'(pxl_color), 32'd1);

        // Parity and stop-bit errors.
        frame_check("par_err_3D", 8'h3D, 1, 0);
        frame_check("good_3D", 8'h3D, 0, 0);
        check("good_3D/color", 32'(pxl_color), 32'd7);
        frame_check("stop_err_45", 8'h45, 0, 1);
        frame_check("brk_then_err", 8'hF0, 0, 0);
        frame_check("err_keeps_brk", 8'h26, 1, 0);
        frame_check("brk_eats_26", 8'h26, 0, 0);

        // Timeout after a partial frame.
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
        ps2_dat = 1'b1;
        wait_clk(TMO + 20);
        check("tmo/frameErr", 32'(fe_cnt - fe0), 32'd1);
        check("tmo/codeValid", 32'(cv_cnt - cv0), 32'd0);
        frame_check("after_tmo_36", 8'h36, 0, 0);
        check("after_tmo/color", 32'(pxl_color), 32'd6);

        // Glitch with data high, then a non-digit key.
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        ps2_dat = 1'b1;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
        wait_clk(TMO + 20);
        check("glitch/frameErr", 32'(fe_cnt - fe0), 32'd0);
        check("glitch/codeValid", 32'(cv_cnt - cv0), 32'd0);
        frame_check("nondigit_1C", 8'h1C, 0, 0);

        // Randomised keys, prefixes and errors.
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            e = int'($urandom_range(0, 7));
            if (r < 5) b = digits[$urandom_range(0, 7)];
            else if (r == 5) b = 8'hF0;
            else if (r == 6) b = 8'hE0;
            else b = 8'($urandom_range(0, 255));
            frame_check($sformatf("rnd%0d", n), b, e == 0, e == 1);
        end

        // Asynchronous reset in the middle of a frame.
        frame_check("pre_rst_2E", 8'h2E, 0, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(posedge clk);
        #7;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst/pxl_color", 32'(pxl_color), 32'd0);
        check("midrst/scanCode", 32'(scanCode), 32'd0);
        check("midrst/codeValid", 32'(codeValid), 32'd0);
        check("midrst/frameErr", 32'(frameErr), 32'd0);
        ps2_dat = 1'b1;
        ps2_clk = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        frame_check("post_rst_1E", 8'h1E, 0, 0);
        check("post_rst/color", 32'(pxl_color), 32'd2);

        wait_clk(5);
        check("exclusive_pulses", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
